// File: rtl/duty_ramp_pkg.sv
// Types and constants shared by the duty ramp and the PWM generator it feeds.
package duty_ramp_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

    localparam logic [6:0] DC_MAX = 7'd100;

    function automatic logic [6:0] clamp_dc(input logic [6:0] d);
        return (d > DC_MAX) ? DC_MAX : d;
    endfunction

endpackage

// File: rtl/duty_ramp_step_tick.sv
// Prescaler: counts enabled cycles and pulses tc on the last count of each DIV-cycle period.
module step_tick #(
    parameter int unsigned DIV = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // With DIV=1 LAST is 0, so tc fires on every enabled cycle.
    assign tc = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/duty_ramp.sv
// Ramps the PWM duty one percent per STEP_DIV clocks toward an accepted target.
module duty_ramp
    import duty_ramp_pkg::*;
#(
    parameter int unsigned STEP_DIV = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tgt_valid,
    input  logic [6:0] tgt_dc,
    output logic       tgt_ready,
    input  logic       hold,
    output logic [6:0] dc,
    output logic       busy,
    output logic       done
);

    ramp_state_t state, state_nx;
    logic [6:0]  target, target_nx, dc_nx, tgt_c;
    logic        done_nx, accept, tick;

    assign tgt_ready = (state == IDLE) && rst_n;
    assign accept    = tgt_valid && tgt_ready;
    assign busy      = (state != IDLE);
    assign tgt_c     = clamp_dc(tgt_dc);

    // Prescaler restarts on every acceptance so the first step lands a full period later.
    step_tick #(.DIV(STEP_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (busy && !hold),
        .clr   (accept),
        .tc    (tick)
    );

    always_comb begin
        state_nx  = state;
        target_nx = target;
        dc_nx     = dc;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    target_nx = tgt_c;
                    if (tgt_c > dc)
                        state_nx = RAMP_UP;
                    else if (tgt_c < dc)
                        state_nx = RAMP_DOWN;
                    else
                        done_nx = 1'b1;
                end
            end
            RAMP_UP: begin
                if (tick) begin
                    dc_nx = dc + 7'd1;
                    if (dc_nx == target) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            RAMP_DOWN: begin
                if (tick) begin
                    dc_nx = dc - 7'd1;
                    if (dc_nx == target) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            dc     <= 7'd0;
            target <= 7'd0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            dc     <= dc_nx;
            target <= target_nx;
            done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_duty_ramp.sv
// Bench for duty_ramp: directed latency scenarios plus random traffic against an arithmetic model.
module tb_duty_ramp;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n, tgt_valid, hold;
    logic [6:0] tgt_dc, dc;
    logic       tgt_ready, busy, done;

    logic       rst1, v1;
    logic [6:0] d1, dc1;
    logic       ready1, busy1, done1;

    always #5 clk = ~clk;

    duty_ramp #(.STEP_DIV(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_dc(tgt_dc),
        .tgt_ready(tgt_ready), .hold(hold), .dc(dc), .busy(busy), .done(done)
    );

    duty_ramp #(.STEP_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst1), .tgt_valid(v1), .tgt_dc(d1),
        .tgt_ready(ready1), .hold(1'b0), .dc(dc1), .busy(busy1), .done(done1)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;
    int n, bc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: dc is start value plus/minus (non-held ramp cycles / S).
    int m_dc = 0, m_tgt = 0, m_d0 = 0, m_prog = 0, m_t;
    bit m_busy = 0, m_done = 0, m_up = 0;

    always @(posedge clk) begin
        m_done = 0;
        if (!rst_n) begin
            m_dc = 0; m_tgt = 0; m_busy = 0; m_prog = 0;
        end else if (!m_busy) begin
            if (tgt_valid) begin
                m_t   = (tgt_dc > 100) ? 100 : int'(tgt_dc);
                m_tgt = m_t;
                if (m_t == m_dc) m_done = 1;
                else begin
                    m_busy = 1; m_d0 = m_dc; m_prog = 0; m_up = (m_t > m_dc);
                end
            end
        end else if (!hold) begin
            m_prog++;
            m_dc = m_up ? m_d0 + m_prog / S : m_d0 - m_prog / S;
            if (m_dc == m_tgt) begin
                m_busy = 0; m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dc", dc, m_dc);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("tgt_ready", tgt_ready, (!m_busy && rst_n));
        end
    end

    task automatic accept(input int d);
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_dc    = 7'(d);
        @(posedge clk);
        #1 tgt_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Counts edges after acceptance until done; optionally injects a hold window or a spurious offer.
    task automatic wait_done(input int hold_dc, input int hold_len, input int spur_n,
                             output int cnt, output int bcnt);
        int hl;
        bit held, want;
        hl = 0; held = 0; want = 0; cnt = 0; bcnt = 0;
        @(negedge clk);
        if (busy) bcnt++;
        while (!done && cnt < 1000) begin
            if (!held && hold_dc >= 0 && int'(dc) == hold_dc) begin
                want = 1; held = 1;
            end
            @(posedge clk);
            cnt++;
            #1;
            if (hl > 0) begin
                hl--;
                if (hl == 0) hold = 1'b0;
            end else if (want) begin
                want = 0; hold = 1'b1; hl = hold_len;
            end
            if (spur_n > 0 && cnt == spur_n) begin
                tgt_valid = 1'b1; tgt_dc = 7'd5;
            end else if (spur_n > 0 && cnt == spur_n + 1) begin
                tgt_valid = 1'b0;
            end
            @(negedge clk);
            if (busy) bcnt++;
            if (spur_n > 0 && cnt == spur_n) chk("spur_ready", tgt_ready, 0);
        end
        hold = 1'b0;
        tgt_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        rst_n = 0; tgt_valid = 0; tgt_dc = 0; hold = 0;
        rst1 = 0; v1 = 0; d1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dc", dc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", tgt_ready, 0);
        chk_en = 1;
        @(posedge clk);
        #1 rst_n = 1; rst1 = 1;

        accept(10);
        wait_done(-1, 0, 0, n, bc);
        chk("up10_lat", n, 40);
        chk("up10_busy", bc, 40);
        chk("up10_dc", dc, 10);
        chk("model_dc10", m_dc, 10);

        do_reset();
        accept(120);
        wait_done(-1, 0, 100, n, bc);
        chk("clamp_lat", n, 400);
        chk("clamp_dc", dc, 100);
        chk("model_dc100", m_dc, 100);

        accept(50);
        wait_done(-1, 0, 0, n, bc);
        chk("down50_lat", n, 200);
        accept(20);
        wait_done(-1, 0, 0, n, bc);
        chk("down20_lat", n, 120);
        chk("down20_busy", bc, 120);
        chk("down20_dc", dc, 20);

        accept(30);
        wait_done(-1, 0, 0, n, bc);
        chk("up30_lat", n, 40);
        accept(30);
        wait_done(-1, 0, 0, n, bc);
        chk("eq_lat", n, 0);
        chk("eq_busy", bc, 0);
        chk("eq_dc", dc, 30);
        @(negedge clk);
        chk("eq_done_low", done, 0);

        do_reset();
        accept(10);
        wait_done(4, 10, 0, n, bc);
        chk("hold_lat", n, 50);
        chk("hold_busy", bc, 50);
        chk("hold_dc", dc, 10);

        do_reset();
        accept(10);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (dc != 7'd5 && k < 200);
        chk("abort_reach5", (k < 200), 1);
        @(posedge clk);
        #1 rst_n = 0;
        @(negedge clk);
        chk("abort_ready_low", tgt_ready, 0);
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("abort_dc", dc, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", tgt_ready, 1);

        repeat (4000) begin
            @(posedge clk);
            #1;
            tgt_valid = ($urandom_range(0, 7) == 0);
            tgt_dc    = ($urandom_range(0, 3) == 0) ? 7'(m_dc) : 7'($urandom_range(0, 127));
            hold      = ($urandom_range(0, 5) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk);
        #1 rst_n = 1; tgt_valid = 0; hold = 0;

        @(negedge clk);
        chk("sd1_ready", ready1, 1);
        v1 = 1; d1 = 7'd3;
        @(posedge clk);
        #1 v1 = 0;
        n = 0;
        @(negedge clk);
        while (!done1 && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("sd1_lat", n, 3);
        chk("sd1_dc", dc1, 3);
        chk("sd1_busy", busy1, 0);

        @(negedge clk);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
